// File: rtl/link_pkg.sv
// Shared constants and types for the board-to-board shot/answer link.
package link_pkg;

    localparam logic [7:0] H_SHOT = 8'hA1;
    localparam logic [7:0] H_MISS = 8'hA2;
    localparam logic [7:0] H_HIT  = 8'hA3;

    localparam int BOARD_N_DEFAULT = 10;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } CELL_T;

    typedef enum logic [3:0] {
        IDLE,
        TX_SH,
        TX_SP,
        WAIT_AH,
        WAIT_AP,
        RX_SP,
        RD,
        RD_WAIT,
        WR,
        TX_AH,
        TX_AP
    } LINK_STATE_T;

    // Position is {row, col}; both must lie in 0..n-1.
    function automatic logic pos_in_range(input logic [7:0] pos, input int n);
        return (32'(pos[7:4]) < n) && (32'(pos[3:0]) < n);
    endfunction

endpackage

// File: rtl/link_timer.sv
// Answer-timeout counter: clears on clr, counts while en and holds at the
// terminal count so tc stays asserted until cleared.
module link_timer #(
    parameter int TIMEOUT_CYCLES = 6_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign tc = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/turn_link_ctl.sv
// Shot/answer sequencer between the game FSM, the own-board RAM and the UART
// byte link: sends own shots with timeout/retry and answers incoming shots.
module turn_link_ctl
    import link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 6_500_000,
    parameter int MAX_RETRY      = 3,
    parameter int BOARD_N        = BOARD_N_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shot_req,
    input  logic [7:0] shot_pos,
    output logic       shot_done,
    output logic       shot_hit,
    output logic       shot_reject,
    output logic       in_done,
    output logic       in_hit,
    output logic [7:0] in_pos,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] brd_addr,
    output logic       brd_rd_en,
    input  logic [1:0] brd_rd_data,
    output logic       brd_wr_en,
    output logic [1:0] brd_wr_data,
    output logic       busy,
    output logic       link_error
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    LINK_STATE_T   state_q, state_d;
    logic [7:0]    shot_pos_q, shot_pos_d;
    logic [7:0]    pend_pos_q, pend_pos_d;
    logic          pending_q, pending_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          hit_q, hit_d;
    logic [7:0]    in_pos_q, in_pos_d;
    logic          in_hit_q, in_hit_d;
    logic          need_wr_q, need_wr_d;
    logic          link_error_q, link_error_d;
    logic          shot_done_q, shot_done_d;
    logic          shot_reject_q, shot_reject_d;
    logic          in_done_q, in_done_d;

    logic waiting, tmr_tc, tx_fire, rx_shot, req_ok;
    logic take_req, serve_pend, timeout;

    assign waiting = (state_q == WAIT_AH) || (state_q == WAIT_AP);
    assign tx_fire = tx_valid & tx_ready;
    assign rx_shot = rx_valid && (rx_data == H_SHOT);
    assign req_ok  = shot_req && pos_in_range(shot_pos, BOARD_N);

    link_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(!waiting),
        .en (waiting),
        .tc (tmr_tc)
    );

    always_comb begin
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        brd_addr    = 8'h00;
        brd_rd_en   = 1'b0;
        brd_wr_en   = 1'b0;
        brd_wr_data = 2'b00;
        case (state_q)
            TX_SH: begin tx_valid = 1'b1; tx_data = H_SHOT;     end
            TX_SP: begin tx_valid = 1'b1; tx_data = shot_pos_q; end
            TX_AH: begin tx_valid = 1'b1; tx_data = in_hit_q ? H_HIT : H_MISS; end
            TX_AP: begin tx_valid = 1'b1; tx_data = in_pos_q;   end
            RD: begin
                brd_addr  = in_pos_q;
                brd_rd_en = 1'b1;
            end
            WR: begin
                brd_addr    = in_pos_q;
                brd_wr_en   = need_wr_q;
                brd_wr_data = need_wr_q ? (in_hit_q ? CELL_HIT : CELL_MISS) : CELL_EMPTY;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        shot_pos_d    = shot_pos_q;
        pend_pos_d    = pend_pos_q;
        pending_d     = pending_q;
        retry_d       = retry_q;
        hit_d         = hit_q;
        in_pos_d      = in_pos_q;
        in_hit_d      = in_hit_q;
        need_wr_d     = need_wr_q;
        link_error_d  = link_error_q;
        shot_done_d   = 1'b0;
        shot_reject_d = 1'b0;
        in_done_d     = 1'b0;
        take_req      = 1'b0;
        serve_pend    = 1'b0;
        timeout       = 1'b0;

        case (state_q)
            IDLE: begin
                // An incoming shot always has priority; a held request waits.
                if (rx_shot) begin
                    state_d = RX_SP;
                end else if (pending_q) begin
                    serve_pend = 1'b1;
                    pending_d  = 1'b0;
                    shot_pos_d = pend_pos_q;
                    retry_d    = '0;
                    state_d    = TX_SH;
                end else if (req_ok) begin
                    take_req   = 1'b1;
                    shot_pos_d = shot_pos;
                    retry_d    = '0;
                    state_d    = TX_SH;
                end
            end
            TX_SH: if (tx_fire) state_d = TX_SP;
            TX_SP: if (tx_fire) state_d = WAIT_AH;
            WAIT_AH: begin
                if (rx_valid && (rx_data == H_MISS || rx_data == H_HIT)) begin
                    hit_d   = (rx_data == H_HIT);
                    state_d = WAIT_AP;
                end else if (tmr_tc) begin
                    timeout = 1'b1;
                end
            end
            WAIT_AP: begin
                if (rx_valid && rx_data == shot_pos_q) begin
                    shot_done_d = 1'b1;
                    state_d     = IDLE;
                end else if (tmr_tc) begin
                    timeout = 1'b1;
                end else if (rx_valid) begin
                    state_d = WAIT_AH;
                end
            end
            RX_SP: begin
                if (rx_valid) begin
                    if (pos_in_range(rx_data, BOARD_N)) begin
                        in_pos_d = rx_data;
                        state_d  = RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                case (CELL_T'(brd_rd_data))
                    CELL_SHIP:  begin in_hit_d = 1'b1; need_wr_d = 1'b1; end
                    CELL_EMPTY: begin in_hit_d = 1'b0; need_wr_d = 1'b1; end
                    CELL_HIT:   begin in_hit_d = 1'b1; need_wr_d = 1'b0; end
                    CELL_MISS:  begin in_hit_d = 1'b0; need_wr_d = 1'b0; end
                endcase
                state_d = WR;
            end
            WR: state_d = TX_AH;
            TX_AH: if (tx_fire) state_d = TX_AP;
            TX_AP: begin
                if (tx_fire) begin
                    in_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                state_d = TX_SH;
            end else begin
                link_error_d = 1'b1;
                state_d      = IDLE;
            end
        end

        // Requests not started directly go to the single pending slot.
        if (shot_req && !take_req) begin
            if (req_ok && (!pending_q || serve_pend)) begin
                pending_d  = 1'b1;
                pend_pos_d = shot_pos;
            end else begin
                shot_reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            shot_pos_q    <= '0;
            pend_pos_q    <= '0;
            pending_q     <= 1'b0;
            retry_q       <= '0;
            hit_q         <= 1'b0;
            in_pos_q      <= '0;
            in_hit_q      <= 1'b0;
            need_wr_q     <= 1'b0;
            link_error_q  <= 1'b0;
            shot_done_q   <= 1'b0;
            shot_reject_q <= 1'b0;
            in_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shot_pos_q    <= shot_pos_d;
            pend_pos_q    <= pend_pos_d;
            pending_q     <= pending_d;
            retry_q       <= retry_d;
            hit_q         <= hit_d;
            in_pos_q      <= in_pos_d;
            in_hit_q      <= in_hit_d;
            need_wr_q     <= need_wr_d;
            link_error_q  <= link_error_d;
            shot_done_q   <= shot_done_d;
            shot_reject_q <= shot_reject_d;
            in_done_q     <= in_done_d;
        end
    end

    assign shot_done   = shot_done_q;
    assign shot_hit    = shot_done_q & hit_q;
    assign shot_reject = shot_reject_q;
    assign in_done     = in_done_q;
    assign in_hit      = in_done_q & in_hit_q;
    assign in_pos      = in_done_q ? in_pos_q : 8'h00;
    assign busy        = (state_q != IDLE);
    assign link_error  = link_error_q;

endmodule

// File: doc/turn_link_ctl.md
Name: turn_link_ctl

Overview:
- Sequences the shot/answer exchange between two boards over the shared UART byte link.
- Own shot: frames the target position from the game FSM, sends it, waits for the opponent's answer with timeout and retry, then reports hit/miss.
- Incoming shot: reads the own-board cell memory, marks it hit/miss and replies.
- Sits between the game-control FSM, the own-board RAM and the UART TX/RX wrappers.

Parameters:
- TIMEOUT_CYCLES, 6_500_000, clk cycles to wait for an answer (100 ms at 65 MHz).
- MAX_RETRY, 3, shot re-transmissions before declaring a link error.
- BOARD_N, 10, board rows/cols; valid coordinate range is 0..BOARD_N-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- shot_req  in  1  one-cycle request to fire at shot_pos
- shot_pos  in  8  {row[7:4], col[3:0]}
- shot_done  out  1  one-cycle pulse: answer received
- shot_hit  out  1  valid with shot_done: 1 = hit
- shot_reject  out  1  one-cycle pulse: request refused (busy or out of range)
- in_done  out  1  one-cycle pulse: incoming shot processed
- in_hit  out  1  valid with in_done
- in_pos  out  8  valid with in_done
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  byte offered; held until tx_ready
- tx_ready  in  1  UART TX accepts byte when tx_valid & tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe per received byte
- brd_addr  out  8  own-board cell address {row,col}
- brd_rd_en  out  1  read strobe; data valid exactly 1 cycle later
- brd_rd_data  in  2  cell code
- brd_wr_en  out  1  write strobe
- brd_wr_data  out  2  cell code written
- busy  out  1  state != IDLE
- link_error  out  1  sticky; cleared only by reset

Behaviour:
- Reset: all outputs 0, state IDLE, retry count 0, timer 0, pending flags cleared. Reset mid-frame abandons the frame; no partial write is issued.
- Frame format, two bytes: header, then position.
  - Header H_SHOT = 0xA1, H_MISS = 0xA2, H_HIT = 0xA3.
  - Answer frames echo the shot position.
- Cell codes: EMPTY = 00, SHIP = 01, HIT = 10, MISS = 11.
- States: IDLE, TX_SH, TX_SP, WAIT_AH, WAIT_AP, RX_SP, RD, RD_WAIT, WR, TX_AH, TX_AP.
- IDLE:
  - rx_valid with H_SHOT -> RX_SP.
  - Else shot_req with row and col < BOARD_N -> latch position, retry = 0 -> TX_SH.
  - Out-of-range request -> shot_reject pulse, stay IDLE.
  - Any other byte is discarded.
- Simultaneous H_SHOT rx and shot_req in IDLE:
  - Incoming shot wins.
  - shot_req is latched as pending and served on return to IDLE, with no re-request needed.
  - Only one pending request is held.
- shot_req while busy and a request already pending -> shot_reject pulse.
- TX_SH / TX_SP:
  - Drive tx_valid with H_SHOT, then the position.
  - Advance only on tx_valid & tx_ready; tx_data stays stable while waiting.
  - After TX_SP is accepted: timer = 0 -> WAIT_AH.
- WAIT_AH:
  - Byte H_MISS or H_HIT -> latch the hit bit -> WAIT_AP.
  - Other bytes are discarded; a colliding H_SHOT is discarded too.
- WAIT_AP:
  - Byte equal to the latched position -> shot_done = 1 with shot_hit for one cycle -> IDLE.
  - Mismatch -> discard -> WAIT_AH.
- Timeout:
  - Timer counts every cycle in WAIT_AH and WAIT_AP.
  - When timer == TIMEOUT_CYCLES-1: if retry < MAX_RETRY, then retry++ and go to TX_SH.
  - Otherwise link_error = 1 -> IDLE, with no shot_done.
  - If an answer byte and the timeout arrive in the same cycle, the byte wins.
- RX_SP:
  - Next rx byte is the position.
  - Row or col out of range -> discard -> IDLE.
  - Else latch it -> RD with brd_rd_en = 1 and brd_addr = position.
- RD_WAIT: sample brd_rd_data.
  - SHIP -> write HIT, answer H_HIT.
  - EMPTY -> write MISS, answer H_MISS.
  - Already HIT -> answer H_HIT, no write.
  - Already MISS -> answer H_MISS, no write.
- WR: single brd_wr_en cycle when a write is needed.
- TX_AH / TX_AP:
  - Send header, then position, using the same handshake as TX_SH / TX_SP.
  - After the position is accepted: in_done with in_hit and in_pos for one cycle -> IDLE.
- rx bytes arriving in RD..TX_AP are dropped.
- Incoming-shot latency, rx position strobe to first tx_valid: 4 cycles.
- Timer width: $clog2(TIMEOUT_CYCLES). Retry counter width: $clog2(MAX_RETRY+1).

Decomposition:
- Package link_pkg:
  - Header constants H_SHOT, H_MISS, H_HIT.
  - Cell enum CELL_T (EMPTY, SHIP, HIT, MISS).
  - State enum LINK_STATE_T.
  - BOARD_N default.
- Sub-module link_timer: clear/enable counter with a terminal-count flag parameterised by TIMEOUT_CYCLES.

Test Plan:
- Fire at 0x34, tx_ready held 1, opponent replies A3,34 -> bytes A1,34 sent; shot_done = 1, shot_hit = 1 one cycle; busy back to 0.
- Incoming A1,25 with cell 0x25 = SHIP -> brd_wr_en with data 10 at 0x25; tx bytes A3,25; in_done with in_hit = 1, in_pos = 0x25.
- Incoming A1,25 again (cell now HIT) -> no write; tx A3,25.
- No answer, MAX_RETRY = 3 -> A1,xx sent 4 times, one TIMEOUT_CYCLES apart; link_error = 1; no shot_done.
- shot_req and rx H_SHOT in the same cycle -> incoming answered first; pending shot then sent with no re-request.
- shot_req with pos 0xA3 -> shot_reject pulse, no tx. Reply A2 followed by a wrong position -> discarded, keeps waiting; the correct A2,pos then gives shot_hit = 0.
